// File: rtl/cmp_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cmp_share_arbiter_if
// Description : Requester-side handshake and result bundle for the shared
//               compare arbiter (two requesters).
// Revision    : 1.0 - initial release
// ============================================================================
interface cmp_share_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_sign;
    logic         req0_ready;
    logic         req0_rvalid;
    logic         req0_lt;
    logic         req0_eq;

    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_sign;
    logic         req1_ready;
    logic         req1_rvalid;
    logic         req1_lt;
    logic         req1_eq;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sign,
        input  req0_ready, req0_rvalid, req0_lt, req0_eq,
        output req1_valid, req1_a, req1_b, req1_sign,
        input  req1_ready, req1_rvalid, req1_lt, req1_eq
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sign,
        output req0_ready, req0_rvalid, req0_lt, req0_eq,
        input  req1_valid, req1_a, req1_b, req1_sign,
        output req1_ready, req1_rvalid, req1_lt, req1_eq
    );
endinterface
`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_share_arbiter
// Description : One shared N-bit lt/eq comparator arbitrated between two
//               requesters, 1-cycle result latency. Define CMP_SHARE_RR_EN for
//               round-robin arbitration (default: fixed priority, req0 wins).
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_share_arbiter #(
    parameter int N = 32
) (
    input  wire                      clk,
    input  wire                      rst,
    cmp_share_arbiter_if.slave       bus
);

`ifdef CMP_SHARE_RR_EN
    localparam bit c_rr_en = 1'b1;
`else
    localparam bit c_rr_en = 1'b0;
`endif

    logic         r_lg_q, w_lg_d;
    logic         r_rvalid0_q, w_rvalid0_d;
    logic         r_rvalid1_q, w_rvalid1_d;
    logic         r_lt0_q, w_lt0_d;
    logic         r_eq0_q, w_eq0_d;
    logic         r_lt1_q, w_lt1_d;
    logic         r_eq1_q, w_eq1_d;

    logic         w_grant0, w_grant1;
    logic [N-1:0] w_a, w_b;
    logic         w_sign;
    logic         w_lo_lt;
    logic         w_lt, w_eq;

    // Requester 1 only wins contention under round-robin when req0 went last.
    always_comb begin
        w_grant1 = 1'b0;
        w_grant0 = 1'b0;
        if (!rst) begin
            w_grant1 = bus.req1_valid &&
                       (!bus.req0_valid || (c_rr_en && (r_lg_q == 1'b0)));
            w_grant0 = bus.req0_valid && !w_grant1;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    assign w_a    = w_grant1 ? bus.req1_a    : bus.req0_a;
    assign w_b    = w_grant1 ? bus.req1_b    : bus.req0_b;
    assign w_sign = w_grant1 ? bus.req1_sign : bus.req0_sign;

    // Shared magnitude compare of the low bits; the MSBs decide when they differ,
    // with the sense flipped between signed and unsigned.
    always_comb begin
        w_lo_lt = (w_a[N-2:0] < w_b[N-2:0]);
        w_eq    = (w_a == w_b);
        if (w_a[N-1] != w_b[N-1]) begin
            w_lt = w_sign ? w_a[N-1] : w_b[N-1];
        end else begin
            w_lt = w_lo_lt;
        end
    end

    always_comb begin
        w_lg_d      = r_lg_q;
        w_rvalid0_d = w_grant0;
        w_rvalid1_d = w_grant1;
        w_lt0_d     = r_lt0_q;
        w_eq0_d     = r_eq0_q;
        w_lt1_d     = r_lt1_q;
        w_eq1_d     = r_eq1_q;
        if (w_grant0) begin
            w_lg_d  = 1'b0;
            w_lt0_d = w_lt;
            w_eq0_d = w_eq;
        end
        if (w_grant1) begin
            w_lg_d  = 1'b1;
            w_lt1_d = w_lt;
            w_eq1_d = w_eq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lg_q      <= 1'b1;
            r_rvalid0_q <= 1'b0;
            r_rvalid1_q <= 1'b0;
            r_lt0_q     <= 1'b0;
            r_eq0_q     <= 1'b0;
            r_lt1_q     <= 1'b0;
            r_eq1_q     <= 1'b0;
        end else begin
            r_lg_q      <= w_lg_d;
            r_rvalid0_q <= w_rvalid0_d;
            r_rvalid1_q <= w_rvalid1_d;
            r_lt0_q     <= w_lt0_d;
            r_eq0_q     <= w_eq0_d;
            r_lt1_q     <= w_lt1_d;
            r_eq1_q     <= w_eq1_d;
        end
    end

    // A result registered just before reset asserts is suppressed while rst is high.
    assign bus.req0_rvalid = r_rvalid0_q && !rst;
    assign bus.req0_lt     = r_lt0_q     && !rst;
    assign bus.req0_eq     = r_eq0_q     && !rst;
    assign bus.req1_rvalid = r_rvalid1_q && !rst;
    assign bus.req1_lt     = r_lt1_q     && !rst;
    assign bus.req1_eq     = r_eq1_q     && !rst;

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_share_arbiter
// Description : Directed plus randomized self-checking bench for
//               cmp_share_arbiter against a behavioural arbitration/compare model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_share_arbiter;
    localparam int N = 32;
`ifdef CMP_SHARE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference state: who went last, and the last result seen by each requester
    bit lg_m  = 1'b1;
    bit e_lt0 = 1'b0, e_eq0 = 1'b0, e_lt1 = 1'b0, e_eq1 = 1'b0;

    cmp_share_arbiter_if #(.N(N)) ifc ();

    cmp_share_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_lt(input logic [N-1:0] a, input logic [N-1:0] b, input bit s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({1'b0, a});
            sb = longint'({1'b0, b});
        end
        return sa < sb;
    endfunction

    task automatic step(input bit r,
                        input bit v0, input logic [N-1:0] a0, input logic [N-1:0] b0, input bit s0,
                        input bit v1, input logic [N-1:0] a1, input logic [N-1:0] b1, input bit s1);
        bit g0, g1;
        @(negedge clk);
        rst            = r;
        ifc.req0_valid = v0; ifc.req0_a = a0; ifc.req0_b = b0; ifc.req0_sign = s0;
        ifc.req1_valid = v1; ifc.req1_a = a1; ifc.req1_b = b1; ifc.req1_sign = s1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!r) begin
            if (v0 && v1) begin
                if (RR && lg_m == 1'b0) g1 = 1'b1; else g0 = 1'b1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("ready0", ifc.req0_ready, g0);
        chk("ready1", ifc.req1_ready, g1);
        if (r) begin
            chk("rst_rvalid0", ifc.req0_rvalid, 1'b0);
            chk("rst_rvalid1", ifc.req1_rvalid, 1'b0);
            chk("rst_lt0", ifc.req0_lt, 1'b0);
            chk("rst_eq1", ifc.req1_eq, 1'b0);
        end
        @(posedge clk);
        #1;
        if (r) begin
            lg_m = 1'b1;
            e_lt0 = 1'b0; e_eq0 = 1'b0; e_lt1 = 1'b0; e_eq1 = 1'b0;
        end
        if (g0) begin
            e_lt0 = ref_lt(a0, b0, s0);
            e_eq0 = (a0 == b0);
            lg_m  = 1'b0;
        end
        if (g1) begin
            e_lt1 = ref_lt(a1, b1, s1);
            e_eq1 = (a1 == b1);
            lg_m  = 1'b1;
        end
        chk("rvalid0", ifc.req0_rvalid, g0);
        chk("rvalid1", ifc.req1_rvalid, g1);
        chk("lt0", ifc.req0_lt, e_lt0);
        chk("eq0", ifc.req0_eq, e_eq0);
        chk("lt1", ifc.req1_lt, e_lt1);
        chk("eq1", ifc.req1_eq, e_eq1);
    endtask

    function automatic logic [N-1:0] pick(input logic [N-1:0] other);
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(N-1){1'b0}}};
            3:       return {1'b0, {(N-1){1'b1}}};
            4:       return other;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        logic [N-1:0] ra0, rb0, ra1, rb1;
        ifc.req0_valid = 1'b0; ifc.req0_a = '0; ifc.req0_b = '0; ifc.req0_sign = 1'b0;
        ifc.req1_valid = 1'b0; ifc.req1_a = '0; ifc.req1_b = '0; ifc.req1_sign = 1'b0;

        // Reset with a pending request that must not be accepted
        step(1, 1, 32'h5, 32'h6, 0, 1, 32'h7, 32'h7, 0);
        step(1, 0, '0, '0, 0, 0, '0, '0, 0);

        // Single requesters, signed and unsigned views of the same operands
        step(0, 1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);

        // Sign-boundary operands
        step(0, 1, 32'h8000_0000, 32'h8000_0000, 1, 0, '0, '0, 0);
        step(0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        step(0, 0, '0, '0, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1);

        // Contention straight after reset
        step(1, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h1, 32'h2, 0, 1, 32'h3, 32'h3, 1);

        // Accept then reset: result dropped, req0 wins first contention after release
        step(0, 0, '0, '0, 0, 1, 32'h9, 32'h1, 0);
        step(1, 0, '0, '0, 0, 0, '0, '0, 0);
        step(0, 1, 32'h0, 32'hFFFF_FFFF, 1, 1, 32'h2, 32'h1, 0);
        step(0, 1, 32'h0, 32'hFFFF_FFFF, 1, 1, 32'h2, 32'h1, 0);
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            ra0 = N'($urandom);
            rb0 = pick(ra0);
            ra1 = pick(rb0);
            rb1 = pick(ra1);
            step(($urandom_range(0, 39) == 0),
                 bit'($urandom_range(0, 1)), ra0, rb0, bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), ra1, rb1, bit'($urandom_range(0, 1)));
        end
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cmp_share_arbiter.md
CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

Interface
REQ-001 Parameter: N, default 32, operand width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (branch unit) has a compare pending.
REQ-005 req0_a, req0_b  input  N each  requester 0 operands.
REQ-006 req0_sign  input  1  1 = signed (2's complement) compare, 0 = unsigned.
REQ-007 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-008 req0_rvalid  output  1  requester 0 result valid, one-cycle pulse.
REQ-009 req0_lt, req0_eq  output  1 each  requester 0 results: a < b, a == b.
REQ-010 req1_valid, req1_a, req1_b, req1_sign, req1_ready, req1_rvalid, req1_lt, req1_eq: same as REQ-004..REQ-009, for requester 1 (ALU SLT/SLTU path).

Function
REQ-011 The block SHALL contain exactly one N-bit less-than datapath (signed and unsigned selected by the granted sign bit) and one N-bit equality compare, shared by both requesters.
REQ-012 A request is accepted when reqX_valid and reqX_ready are both high in the same cycle; reqX_ready SHALL be combinational from current valids and arbiter state, and high for at most one requester per cycle.
REQ-013 A requester SHALL hold valid, operands and sign stable until accepted; the block samples them only in the accept cycle.
REQ-014 Only one requester valid: that requester SHALL be granted the same cycle.
REQ-015 Both valid: grant SHALL follow the arbitration policy in REQ-024/REQ-025.
REQ-016 Result stage: on accept, lt/eq SHALL be registered; reqX_rvalid SHALL be high exactly the next cycle (latency 1), with reqX_lt/reqX_eq valid in that cycle.
REQ-017 The block SHALL accept one request every cycle (throughput 1); back-to-back accepts produce back-to-back rvalid pulses, alternating between requesters as granted.
REQ-018 Results carry no backpressure; the requester SHALL capture them in the rvalid cycle.
REQ-019 reqX_lt/reqX_eq SHALL hold their last value when reqX_rvalid is low.
REQ-020 Signed compare: differing sign bits decide (a negative, b non-negative -> lt=1; the converse -> lt=0); equal sign bits -> unsigned compare of bits N-2:0.
REQ-021 Unsigned compare: full N-bit magnitude; eq is sign-independent.
REQ-022 Arbiter state: a 1-bit last-grant register (LG), updated only on an accept, set to the index of the accepted requester.

Reset
REQ-023 While rst is high at a rising edge: req0_rvalid=req1_rvalid=0, req0_lt=req0_eq=req1_lt=req1_eq=0, LG=1 (so requester 0 wins the first contention); a request accepted in the cycle rst is asserted SHALL be discarded (no rvalid after reset); ready SHALL be low while rst is high.

Configuration
REQ-024 Macro CMP_SHARE_RR_EN defined: round-robin; on contention the requester not equal to LG SHALL be granted.
REQ-025 Macro CMP_SHARE_RR_EN undefined: fixed priority; on contention requester 0 SHALL always be granted; LG is still maintained but does not affect grant.

Verification
REQ-026 Only req0_valid, a=0xFFFFFFFF, b=0x00000001, sign=1 -> req0_ready=1 same cycle; next cycle req0_rvalid=1, req0_lt=1, req0_eq=0.
REQ-027 Only req1_valid, same operands, sign=0 -> next cycle req1_rvalid=1, req1_lt=0, req1_eq=0; req0_rvalid stays 0.
REQ-028 Both valid for 4 cycles after reset, RR_EN defined -> grants 0,1,0,1; rvalid pulses 0,1,0,1 one cycle later; RR_EN undefined -> grants 0,0,0,0, req1_ready never high.
REQ-029 a=b=0x80000000, sign=1 -> lt=0, eq=1; a=0x7FFFFFFF, b=0x80000000: sign=1 -> lt=0, sign=0 -> lt=1.
REQ-030 Accept in cycle k, rst high in cycle k+1 -> rvalid=0 and lt=eq=0 in cycle k+1 and k+2; first grant after rst release goes to requester 0 under contention.
